// File: rtl/work_loader.sv
// work_loader: frames UART bytes into one mining work unit for sha_hasher.
// Optional trailing XOR checksum: define WORK_LOADER_CHECKSUM_EN.
module work_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [255:0] digest_initial_out,
  output logic [255:0] digest_out,
  output logic [31:0]  merkle_out,
  output logic [31:0]  time_out,
  output logic [31:0]  target_out,
  output logic [31:0]  nonce_out,
  output logic         write_en,
  output logic         frame_err,
  output logic         busy,
  output logic [7:0]   frame_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
`ifdef WORK_LOADER_CHECKSUM_EN
    S_CHECK   = 2'd2,
`endif
    S_COMMIT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [6:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic          r_we;
  logic          r_err;
  logic [7:0]    r_fc;
  logic [255:0]  r_di;
  logic [255:0]  r_dg;
  logic [31:0]   r_mk;
  logic [31:0]   r_tm;
  logic [31:0]   r_tg;
  logic [31:0]   r_nc;

  logic [639:0]  w_full;
  logic [639:0]  w_src;
  logic          w_last;
  logic          w_commit;
  logic          w_tmo;

`ifdef WORK_LOADER_CHECKSUM_EN
  logic [639:0]  r_shadow;
  logic [7:0]    r_acc;
  logic          w_ck_ok;

  assign w_full  = {r_shadow[631:0], rx_data};
  assign w_ck_ok = (rx_data == r_acc);
  assign w_src   = r_shadow;
  assign w_commit = rx_valid && (r_state == S_CHECK) && w_ck_ok;
`else
  // The final byte bypasses the shadow, so 79 stored bytes suffice.
  logic [631:0]  r_shadow;

  assign w_full   = {r_shadow, rx_data};
  assign w_src    = w_full;
  assign w_commit = rx_valid && (r_state == S_PAYLOAD) && w_last;
`endif

  assign w_last = (r_cnt == 7'd79);
  assign w_tmo  = (r_tmo == TMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
      r_shadow <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
      r_acc    <= '0;
`endif
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE, S_COMMIT: begin
          r_tmo   <= '0;
          r_state <= S_IDLE;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            r_state <= S_PAYLOAD;
            r_cnt   <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
            r_acc   <= '0;
`endif
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            r_shadow <= w_full[$bits(r_shadow)-1:0];
            r_cnt    <= r_cnt + 7'd1;
            r_tmo    <= '0;
`ifdef WORK_LOADER_CHECKSUM_EN
            r_acc    <= r_acc ^ rx_data;
            if (w_last) r_state <= S_CHECK;
`else
            if (w_last) r_state <= S_COMMIT;
`endif
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
`ifdef WORK_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid) begin
            r_tmo   <= '0;
            r_state <= w_ck_ok ? S_COMMIT : S_IDLE;
            r_err   <= !w_ck_ok;
          end else if (w_tmo) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs load on the final byte edge so they appear with write_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_fc <= '0;
      r_di <= '0;
      r_dg <= '0;
      r_mk <= '0;
      r_tm <= '0;
      r_tg <= '0;
      r_nc <= '0;
    end else begin
      r_we <= w_commit;
      if (w_commit) begin
        r_fc <= r_fc + 8'd1;
        r_di <= w_src[639:384];
        r_dg <= w_src[383:128];
        r_mk <= w_src[127:96];
        r_tm <= w_src[95:64];
        r_tg <= w_src[63:32];
        r_nc <= w_src[31:0];
      end
    end
  end

  assign digest_initial_out = r_di;
  assign digest_out         = r_dg;
  assign merkle_out         = r_mk;
  assign time_out           = r_tm;
  assign target_out         = r_tg;
  assign nonce_out          = r_nc;
  assign write_en           = r_we;
  assign frame_err          = r_err;
  assign frame_count        = r_fc;
  assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_work_loader.sv
// tb_work_loader: directed + random frames against a byte-array model.
// Checksum byte is sent only when WORK_LOADER_CHECKSUM_EN is defined.
module tb_work_loader;

  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [255:0] digest_initial_out;
  logic [255:0] digest_out;
  logic [31:0]  merkle_out;
  logic [31:0]  time_out;
  logic [31:0]  target_out;
  logic [31:0]  nonce_out;
  logic         write_en;
  logic         frame_err;
  logic         busy;
  logic [7:0]   frame_count;

  work_loader #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .digest_initial_out(digest_initial_out),
    .digest_out(digest_out),
    .merkle_out(merkle_out), .time_out(time_out),
    .target_out(target_out), .nonce_out(nonce_out),
    .write_en(write_en), .frame_err(frame_err),
    .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int err_cnt = 0;
  logic [7:0]   pl [80];
  logic [639:0] exp_w = '0;
  logic [7:0]   exp_fc = '0;

  task automatic chk(input string tag, input logic [639:0] o,
                     input logic [639:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    if (write_en) we_cnt++;
    if (frame_err) err_cnt++;
    if (rst_n) chk("we_err_excl", 640'(write_en && frame_err), 640'(0));
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  function automatic void rand_pl();
    for (int i = 0; i < 80; i++) pl[i] = 8'($urandom);
  endfunction

  function automatic void put32(input int idx, input logic [31:0] v);
    for (int k = 0; k < 4; k++) pl[idx+k] = v[31-8*k -: 8];
  endfunction

  function automatic logic [639:0] model_pack();
    logic [639:0] r = '0;
    for (int i = 0; i < 80; i++) r = (r << 8) | 640'(pl[i]);
    return r;
  endfunction

  function automatic logic [7:0] model_xsum();
    logic [7:0] x = '0;
    for (int i = 0; i < 80; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic send_payload();
    send(8'hA5);
    for (int i = 0; i < 80; i++) send(pl[i]);
  endtask

  task automatic send_frame();
    send_payload();
`ifdef WORK_LOADER_CHECKSUM_EN
    send(model_xsum());
`endif
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_di"}, 640'(digest_initial_out), 640'(exp_w[639:384]));
    chk({tag, "_dg"}, 640'(digest_out), 640'(exp_w[383:128]));
    chk({tag, "_mk"}, 640'(merkle_out), 640'(exp_w[127:96]));
    chk({tag, "_tm"}, 640'(time_out), 640'(exp_w[95:64]));
    chk({tag, "_tg"}, 640'(target_out), 640'(exp_w[63:32]));
    chk({tag, "_nc"}, 640'(nonce_out), 640'(exp_w[31:0]));
    chk({tag, "_fc"}, 640'(frame_count), 640'(exp_fc));
  endtask

  task automatic good_frame(input string tag);
    int w0;
    w0 = we_cnt;
    send_frame();
    exp_w  = model_pack();
    exp_fc = exp_fc + 8'd1;
    chk({tag, "_we"}, 640'(write_en), 640'(1));
    chk({tag, "_busy"}, 640'(busy), 640'(1));
    chk_fields(tag);
    @(posedge clk);
    #1;
    chk({tag, "_we_off"}, 640'(write_en), 640'(0));
    chk({tag, "_busy_off"}, 640'(busy), 640'(0));
    chk({tag, "_we_once"}, 640'(we_cnt - w0), 640'(1));
  endtask

  initial begin
    int n;
    int e0;
    int w0;

    repeat (3) @(posedge clk);
    #1;
    chk_fields("rst");
    chk("rst_we", 640'(write_en), 640'(0));
    chk("rst_err", 640'(frame_err), 640'(0));
    chk("rst_busy", 640'(busy), 640'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rand_pl();
    put32(0, 32'hF59007B5);
    put32(28, 32'h3BC75771);
    put32(32, 32'hF7A528B9);
    put32(60, 32'hFA09E776);
    put32(64, 32'h252DB801);
    put32(68, 32'h130DAE51);
    put32(72, 32'h6461011A);
    put32(76, 32'h3AEB9BB0);

`ifdef WORK_LOADER_CHECKSUM_EN
    w0 = we_cnt;
    send_payload();
    send(model_xsum() ^ 8'h01);
    chk("bad_err", 640'(frame_err), 640'(1));
    chk("bad_we", 640'(write_en), 640'(0));
    chk_fields("bad");
    @(posedge clk);
    #1;
    chk("bad_err_off", 640'(frame_err), 640'(0));
    chk("bad_no_we", 640'(we_cnt - w0), 640'(0));
`endif

    good_frame("good");
    chk("good_mk_lit", 640'(merkle_out), 640'(32'h252DB801));
    chk("good_nc_lit", 640'(nonce_out), 640'(32'h3AEB9BB0));
    chk("good_di_top", 640'(digest_initial_out[255:224]),
        640'(32'hF59007B5));

    send(8'hA5);
    for (int i = 0; i < 40; i++) send(8'($urandom));
    n = 0;
    for (int c = 1; c <= TMO + 8; c++) begin
      @(posedge clk);
      #1;
      if (frame_err && n == 0) n = c;
    end
    chk("tmo_latency", 640'(n), 640'(TMO));
    chk("tmo_busy", 640'(busy), 640'(0));
    chk_fields("tmo_hold");
    rand_pl();
    good_frame("after_tmo");

    rand_pl();
    pl[0] = 8'hA5;
    pl[10] = 8'hA5;
    pl[79] = 8'hA5;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    chk("noise_busy", 640'(busy), 640'(0));
    good_frame("sync_data");

    e0 = err_cnt;
    rand_pl();
    send(8'hA5);
    for (int i = 0; i < 30; i++) send(pl[i]);
    #2;
    rst_n = 1'b0;
    #1;
    exp_w  = '0;
    exp_fc = '0;
    chk_fields("midrst");
    chk("midrst_busy", 640'(busy), 640'(0));
    chk("midrst_err", 640'(frame_err), 640'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_err", 640'(err_cnt - e0), 640'(0));
    rand_pl();
    good_frame("after_rst");

    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    exp_fc = '0;
    @(posedge clk);
    #1;
    w0 = we_cnt;
    for (int f = 0; f < 256; f++) begin
      rand_pl();
      send_frame();
      exp_fc = exp_fc + 8'd1;
      chk("wrap_we", 640'(write_en), 640'(1));
      chk("wrap_fc", 640'(frame_count), 640'(exp_fc));
    end
    exp_w = model_pack();
    @(posedge clk);
    #1;
    chk("wrap_total_we", 640'(we_cnt - w0), 640'(256));
    chk("wrap_zero", 640'(frame_count), 640'(0));
    chk_fields("wrap_last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
